// File: rtl/counter_sequencer_pkg.sv
// counter_seq_pkg: state encoding and command opcodes shared by counter_sequencer and its bench.
package counter_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_e;
    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;
endpackage

// File: rtl/counter_sequencer_count_core.sv
// count_core: falling-edge synchronous toggle counter with clear priority over enable.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] cnt_q, cnt_d, tgl;
    assign tgl[0] = en;
    for (genvar k = 1; k < WIDTH; k++) begin : g_tgl
        assign tgl[k] = en & (&cnt_q[k-1:0]);
    end
    always_comb cnt_d = clr ? '0 : cnt_q ^ tgl;
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign q = cnt_q;
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven interval counter FSM around count_core.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_periodic,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic             err
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             periodic_q, periodic_d;
    logic             tick_q, tick_d, done_q, done_d, err_q, err_d;
    logic             en, clr, acc, term, pause;

    count_core #(.WIDTH(WIDTH)) u_core (.clk(clk), .rst(rst), .en(en), .clr(clr), .q(q));

    assign acc  = cmd_valid & cmd_ready;
    assign term = q == limit_q;

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        en         = 1'b0;
        clr        = 1'b0;
        pause      = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && cmd_op == OP_START) begin
                    limit_d    = cmd_limit;
                    periodic_d = cmd_periodic;
                    clr        = 1'b1;
                    state_d    = RUN;
                end
                err_d = acc && (cmd_op == OP_PAUSE || cmd_op == OP_RESUME);
            end
            RUN: begin
                if (acc && cmd_op == OP_ABORT) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end else begin
                    // a PAUSE landing on the terminal count still ticks; one-shot completion consumes it
                    pause = acc && cmd_op == OP_PAUSE;
                    err_d = acc && (cmd_op == OP_START || cmd_op == OP_RESUME);
                    if (term) begin
                        tick_d  = 1'b1;
                        done_d  = !periodic_q;
                        clr     = periodic_q;
                        state_d = !periodic_q ? DONE : pause ? PAUSED : RUN;
                    end else begin
                        en      = !pause;
                        state_d = pause ? PAUSED : RUN;
                    end
                end
            end
            PAUSED: begin
                if (acc && cmd_op == OP_RESUME) state_d = RUN;
                if (acc && cmd_op == OP_ABORT) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
                err_d = acc && (cmd_op == OP_START || cmd_op == OP_PAUSE);
            end
            DONE: begin
                clr     = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = state_q != DONE;
    assign busy      = state_q == RUN || state_q == PAUSED;
    assign tick      = tick_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed vectors with a queue-based scoreboard sampled on the rising edge.
module tb_counter_sequencer;
    import counter_seq_pkg::*;
    localparam int W = 4;

    logic         clk = 1'b1, rst = 1'b0;
    logic         cmd_valid = 1'b0, cmd_periodic = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_limit = '0;
    logic         cmd_ready, busy, tick, done, err;
    logic [W-1:0] q;
    logic [8:0]   exp_q[$];
    int           n_vec = 0, n_miss = 0;
    string        phase = "reset";

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_limit(cmd_limit), .cmd_periodic(cmd_periodic), .q(q), .busy(busy), .tick(tick),
        .done(done), .err(err)
    );

    function automatic logic [8:0] pk(int cq, int b, int t, int d, int e, int r);
        return {4'(cq), 1'(b), 1'(t), 1'(d), 1'(e), 1'(r)};
    endfunction

    task automatic chk(string name, logic [8:0] got, logic [8:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got q=%0d busy/tick/done/err/rdy=%b, want q=%0d busy/tick/done/err/rdy=%b",
                     name, got[8:5], got[4:0], want[8:5], want[4:0]);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, the DUT acts on the falling edge,
    // and the expectation is checked on the next rising edge.
    task automatic drive(logic v, logic [1:0] op, int lim, logic per,
                         int cq, int b, int t, int d, int e, int r);
        @(posedge clk);
        #1;
        cmd_valid    = v;
        cmd_op       = op;
        cmd_limit    = W'(lim);
        cmd_periodic = per;
        exp_q.push_back(pk(cq, b, t, d, e, r));
    endtask

    task automatic idle(int cq, int b, int t, int d, int e, int r);
        drive(1'b0, cmd_op, int'(cmd_limit), cmd_periodic, cq, b, t, d, e, r);
    endtask

    always @(posedge clk)
        if (exp_q.size() != 0)
            chk($sformatf("%s#%0d", phase, n_vec), {q, busy, tick, done, err, cmd_ready}, exp_q.pop_front());

    initial begin
        idle(0, 0, 0, 0, 0, 1);
        idle(0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        idle(0, 0, 0, 0, 0, 1);

        phase = "oneshot3";
        drive(1, OP_START, 3, 0, 0, 1, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) idle(i, 1, 0, 0, 0, 1);
        idle(3, 0, 1, 1, 0, 0);
        idle(0, 0, 0, 0, 0, 1);

        phase = "periodic4";
        drive(1, OP_START, 4, 1, 0, 1, 0, 0, 0, 1);
        for (int i = 1; i < 20; i++) idle(i % 5, 1, int'(i % 5 == 0), 0, 0, 1);
        phase = "abort_at_limit";
        drive(1, OP_ABORT, 0, 0, 0, 0, 0, 0, 0, 1);

        phase = "pause_resume";
        drive(1, OP_START, 7, 1, 0, 1, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) idle(i, 1, 0, 0, 0, 1);
        drive(1, OP_PAUSE, 0, 0, 3, 1, 0, 0, 0, 1);
        repeat (4) idle(3, 1, 0, 0, 0, 1);
        drive(1, OP_RESUME, 0, 0, 3, 1, 0, 0, 0, 1);
        for (int i = 4; i <= 7; i++) idle(i, 1, 0, 0, 0, 1);
        idle(0, 1, 1, 0, 0, 1);
        for (int i = 1; i <= 7; i++) idle(i, 1, 0, 0, 0, 1);
        phase = "pause_at_limit";
        drive(1, OP_PAUSE, 0, 0, 0, 1, 1, 0, 0, 1);
        idle(0, 1, 0, 0, 0, 1);
        drive(1, OP_PAUSE, 0, 0, 0, 1, 0, 0, 1, 1);
        drive(1, OP_RESUME, 0, 0, 0, 1, 0, 0, 0, 1);
        idle(1, 1, 0, 0, 0, 1);
        drive(1, OP_ABORT, 0, 0, 0, 0, 0, 0, 0, 1);

        phase = "oneshot_pause_at_limit";
        drive(1, OP_START, 2, 0, 0, 1, 0, 0, 0, 1);
        idle(1, 1, 0, 0, 0, 1);
        idle(2, 1, 0, 0, 0, 1);
        drive(1, OP_PAUSE, 0, 0, 2, 0, 1, 1, 0, 0);
        idle(0, 0, 0, 0, 0, 1);

        phase = "illegal";
        drive(1, OP_RESUME, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(0, 0, 0, 0, 0, 1);
        drive(1, OP_PAUSE, 0, 0, 0, 0, 0, 0, 1, 1);
        drive(1, OP_ABORT, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, OP_START, 5, 1, 0, 1, 0, 0, 0, 1);
        idle(1, 1, 0, 0, 0, 1);
        drive(1, OP_START, 2, 0, 2, 1, 0, 0, 1, 1);
        for (int i = 3; i <= 5; i++) idle(i, 1, 0, 0, 0, 1);
        idle(0, 1, 1, 0, 0, 1);
        drive(1, OP_RESUME, 0, 0, 1, 1, 0, 0, 1, 1);
        drive(1, OP_ABORT, 0, 0, 0, 0, 0, 0, 0, 1);

        phase = "limit0_periodic";
        drive(1, OP_START, 0, 1, 0, 1, 0, 0, 0, 1);
        repeat (4) idle(0, 1, 1, 0, 0, 1);
        drive(1, OP_ABORT, 0, 0, 0, 0, 0, 0, 0, 1);

        phase = "limit0_oneshot";
        drive(1, OP_START, 0, 0, 0, 1, 0, 0, 0, 1);
        idle(0, 0, 1, 1, 0, 0);
        drive(1, OP_START, 3, 1, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0, 0, 0, 1);

        phase = "limit15";
        drive(1, OP_START, 15, 0, 0, 1, 0, 0, 0, 1);
        for (int i = 1; i <= 15; i++) idle(i, 1, 0, 0, 0, 1);
        idle(15, 0, 1, 1, 0, 0);
        idle(0, 0, 0, 0, 0, 1);

        phase = "async_reset";
        drive(1, OP_START, 9, 1, 0, 1, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) idle(i, 1, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_reset_now", {q, busy, tick, done, err, cmd_ready}, pk(0, 0, 0, 0, 0, 1));
        exp_q.push_back(pk(0, 0, 0, 0, 0, 1));
        idle(0, 0, 0, 0, 0, 1);
        rst = 1'b1;

        phase = "after_reset";
        drive(1, OP_START, 2, 1, 0, 1, 0, 0, 0, 1);
        idle(1, 1, 0, 0, 0, 1);
        idle(2, 1, 0, 0, 0, 1);
        idle(0, 1, 1, 0, 0, 1);
        drive(1, OP_ABORT, 0, 0, 0, 0, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
